mio_ram_arb: RTL and testbench
==============================

MIO_RAM_ARB -- requirements
Module: mio_ram_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning RAM data width.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 RSTN  in  1  asynchronous, active-low reset.
REQ-005 a_req  in  1  port A (CPU side) access request, level, held until a_ready.
REQ-006 a_we  in  1  port A write (1) / read (0), valid with a_req.
REQ-007 a_addr  in  ADDR_W  port A word address.
REQ-008 a_wdata  in  DATA_W  port A write data.
REQ-009 a_rdata  out  DATA_W  port A read data, valid when a_ready=1 on a read.
REQ-010 a_ready  out  1  port A completion pulse, one cycle.
REQ-011 b_req, b_we, b_addr, b_wdata, b_rdata, b_ready  same widths and meanings for port B (loader/debug side).
REQ-012 ram_addr  out  ADDR_W  registered address to the block RAM.
REQ-013 ram_we  out  1  registered write enable to the block RAM.
REQ-014 ram_din  out  DATA_W  registered write data to the block RAM.
REQ-015 ram_dout  in  DATA_W  RAM read data; valid one clk after the address is sampled.
REQ-016 grant  out  2  owner of the current access: 01=A, 10=B, 00=idle.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, RESP and DONE.
- IDLE: no request -> stay; any request -> arbitrate, register the winner's addr/we/wdata onto ram_*, set grant, go to ACCESS.
- ACCESS -> RESP; RESP -> DONE; DONE -> IDLE, unconditionally.
REQ-018 ram_we SHALL be high only during ACCESS, and only for write transactions.
REQ-019 On a read, the winner's rdata register SHALL load ram_dout on the RESP->DONE edge; on a write, rdata SHALL hold its previous value.
REQ-020 The winner's ready SHALL be high for exactly the DONE cycle; the loser's ready and rdata SHALL be unchanged.
REQ-021 Latency: ready SHALL assert 3 cycles after the edge on which IDLE samples the request; throughput is one access per 4 cycles.
REQ-022 Requests SHALL be re-sampled only in IDLE; a req dropped mid-transaction SHALL NOT abort the access, and ready still pulses.
REQ-023 A requester that keeps req high after its ready SHALL be treated as a new request in the following IDLE cycle.
REQ-024 With a single requester, that requester SHALL win; with neither requesting, grant=00 and ram_we=0.
REQ-025 Simultaneous requests SHALL be resolved per REQ-029/REQ-030; last_grant SHALL update on every grant.
REQ-026 Addresses SHALL be passed unmodified, 0 to 2^ADDR_W-1; no wrap or range checking.

Reset
REQ-027 When RSTN=0, the block SHALL immediately set:
- state IDLE; grant=00; ram_we=0;
- ram_addr=0, ram_din=0;
- a_rdata=b_rdata=0; a_ready=b_ready=0;
- last_grant=B.
REQ-028 Reset mid-transaction SHALL abandon the access with no ready pulse; ram_we SHALL drop without waiting for clk.

Configuration
REQ-029 With macro MIO_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not in last_grant (A first after reset).
REQ-030 Without MIO_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always go to port A (fixed priority), and last_grant is unused.

Verification
REQ-031 Write then read: A writes 0xDEADBEEF to 0x3FF, then reads 0x3FF -> a_ready 3 cycles after each sample, a_rdata=0xDEADBEEF, b_ready stays 0.
REQ-032 Contention, macro defined: A and B both request continuously, 4 accesses -> grant sequence A,B,A,B, one ready per 4 cycles.
REQ-033 Contention, macro undefined: same stimulus -> grant A,A,A,A; B is served only after a_req drops.
REQ-034 Reset mid-access: assert RSTN=0 during ACCESS of a write -> ram_we=0 before the next edge; no ready; after release, grant=00 and state is IDLE.
REQ-035 Drop req: B reads 0x000 holding 0x12345678 and drops b_req in ACCESS -> b_ready pulses with b_rdata=0x12345678; no second access.

Source files
------------

// File: rtl/mio_ram_arb.sv
// mio_ram_arb: two-port arbiter in front of a single-port block RAM.
// Port A is the CPU side and port B is the loader/debug side. Each access
// takes four cycles: IDLE, ACCESS, RESP and DONE. The RAM address, write
// enable and write data are all registered.
// Optional feature: define MIO_ARB_ROUND_ROBIN_EN to select round-robin
// arbitration for simultaneous requests. Without it, port A has fixed
// priority.
module mio_ram_arb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ready,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

  state_t state, state_nxt;
  logic   win_a, win_b;
  logic   cur_we;       // direction of the access in flight; ram_we drops after ACCESS

`ifdef MIO_ARB_ROUND_ROBIN_EN
  logic [1:0] last_grant;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. Requests are arbitrated only in IDLE.
  // NOTE: every signal gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    win_a     = 1'b0;
    win_b     = 1'b0;
    case (state)
      IDLE: begin
`ifdef MIO_ARB_ROUND_ROBIN_EN
        if (a_req && b_req) begin
          win_a = (last_grant != 2'b01);
          win_b = !win_a;
        end else begin
          win_a = a_req;
          win_b = b_req;
        end
`else
        win_a = a_req;
        win_b = b_req && !a_req;
`endif
        if (a_req || b_req) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MIO_ARB_ROUND_ROBIN_EN
  // Record the most recent winner. After reset it reads as B, so A is served first.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN)               last_grant <= 2'b10;
    else if (win_a || win_b) last_grant <= {win_b, win_a};
  end
`endif

  // Datapath: launch the RAM access, capture read data, and pulse ready.
  // NOTE: the async reset clears ram_we at once, so a write aborted during ACCESS never reaches the RAM.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      grant    <= 2'b00;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      cur_we   <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      a_ready  <= 1'b0;
      b_ready  <= 1'b0;
    end else begin
      a_ready <= 1'b0;
      b_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (win_a || win_b) begin
            grant    <= {win_b, win_a};
            cur_we   <= win_a ? a_we    : b_we;
            ram_we   <= win_a ? a_we    : b_we;
            ram_addr <= win_a ? a_addr  : b_addr;
            ram_din  <= win_a ? a_wdata : b_wdata;
          end
        end
        ACCESS: ram_we <= 1'b0;
        RESP: begin
          a_ready <= grant[0];
          b_ready <= grant[1];
          if (!cur_we) begin
            if (grant[0]) a_rdata <= ram_dout;
            if (grant[1]) b_rdata <= ram_dout;
          end
        end
        DONE:    grant <= 2'b00;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_ram_arb.sv
// tb_mio_ram_arb: self-checking bench for mio_ram_arb.
// The bench contains a block-RAM model with registered read. It also keeps a
// transaction-level reference: a shadow memory, the expected read data for
// each port, and the identity of the last winner.
module tb_mio_ram_arb;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
`ifdef MIO_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              RSTN;
  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr, ram_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_din, ram_dout;
  logic              a_ready, b_ready, ram_we;
  logic [1:0]        grant;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state (last_owner: 0 = A, 1 = B).
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  logic [DATA_W-1:0] exp_a_rdata, exp_b_rdata;
  bit                last_owner;

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  mio_ram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .RSTN(RSTN),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ready(a_ready),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ready(b_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .grant(grant)
  );

  always #5 clk = ~clk;

  // Block RAM: the address is sampled on the edge and the data is valid one clk later.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'(i) * 32'h9E3779B1;
  end

  // Winner rule for a request pattern: 0 = A, 1 = B.
  function automatic bit pick(input bit ra, input bit rb);
    if (ra && rb) return RR ? !last_owner : 1'b0;
    return !ra;
  endfunction

  function automatic logic [1:0] code(input bit owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    last_owner  = 1'b1;
    exp_a_rdata = '0;
    exp_b_rdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    RSTN  = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    RSTN = 1'b1;
    model_reset();
  endtask

  // One access, started from an IDLE cycle. Reqs are dropped on cycle drop_at (or in DONE).
  task automatic run_txn(input bit ra, input bit rb, input bit wa, input bit wb,
                         input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ab,
                         input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db,
                         input int drop_at);
    bit                owner;
    bit                w_we;
    logic [1:0]        wcode;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    @(negedge clk);
    vectors++;
    if (grant !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_grant got %b want 00", grant);
    end
    a_req = ra; a_we = wa; a_addr = aa; a_wdata = da;
    b_req = rb; b_we = wb; b_addr = ab; b_wdata = db;
    owner  = pick(ra, rb);
    wcode  = code(owner);
    w_we   = owner ? wb : wa;
    w_addr = owner ? ab : aa;
    w_data = owner ? db : da;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      vectors++;
      if ({b_ready, a_ready} !== ((cyc == 3) ? wcode : 2'b00)) begin
        miscompares++;
        $display("FAIL ready_cycle%0d got %b want %b", cyc, {b_ready, a_ready},
                 (cyc == 3) ? wcode : 2'b00);
      end
      vectors++;
      if (grant !== wcode) begin
        miscompares++;
        $display("FAIL grant_cycle%0d got %b want %b", cyc, grant, wcode);
      end
      if (cyc == 1) begin
        vectors++;
        if (ram_we !== w_we || ram_addr !== w_addr || (w_we && ram_din !== w_data)) begin
          miscompares++;
          $display("FAIL ram_launch got we=%b addr=%h din=%h want we=%b addr=%h din=%h",
                   ram_we, ram_addr, ram_din, w_we, w_addr, w_data);
        end
      end
      if (cyc == 2) begin
        vectors++;
        if (ram_we !== 1'b0) begin
          miscompares++;
          $display("FAIL ram_we_resp got %b want 0", ram_we);
        end
      end
      if (cyc == 3) begin
        if (w_we) ref_mem[w_addr] = w_data;
        else if (owner) exp_b_rdata = ref_mem[w_addr];
        else exp_a_rdata = ref_mem[w_addr];
        last_owner = owner;
        vectors++;
        if (a_rdata !== exp_a_rdata || b_rdata !== exp_b_rdata) begin
          miscompares++;
          $display("FAIL rdata got a=%h b=%h want a=%h b=%h", a_rdata, b_rdata,
                   exp_a_rdata, exp_b_rdata);
        end
      end
      if (cyc == drop_at || cyc == 3) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (grant !== 2'b00 || ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== '0) begin
      miscompares++;
      $display("FAIL reset_ram got grant=%b we=%b addr=%h din=%h want 00/0/0/0",
               grant, ram_we, ram_addr, ram_din);
    end
    vectors++;
    if (a_rdata !== '0 || b_rdata !== '0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ports got a=%h/%b b=%h/%b want zeros", a_rdata, a_ready,
               b_rdata, b_ready);
    end
    RSTN = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (grant !== 2'b00 || {b_ready, a_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset got grant=%b ready=%b want 00/00", grant,
               {b_ready, a_ready});
    end
  endtask

  task automatic test_write_read();
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 10'h3FF, '0, 32'hDEADBEEF, '0, 3);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF, '0, '0, '0, 3);
    vectors++;
    if (a_rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_read got %h want deadbeef", a_rdata);
    end
  endtask

  task automatic test_drop_req();
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, '0, 10'h000, '0, 32'h12345678, 3);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, '0, 10'h000, '0, '0, 1);
    vectors++;
    if (b_rdata !== 32'h12345678) begin
      miscompares++;
      $display("FAIL drop_req_rdata got %h want 12345678", b_rdata);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({b_ready, a_ready} !== 2'b00 || grant !== 2'b00) begin
        miscompares++;
        $display("FAIL drop_req_extra got ready=%b grant=%b want 00/00",
                 {b_ready, a_ready}, grant);
      end
    end
  endtask

  task automatic test_contention();
    bit owners [5];
    int n;
    int last_cyc;
    apply_reset();
    n = RR ? 4 : 5;
    for (int k = 0; k < 4; k++) begin
      owners[k]  = pick(1'b1, 1'b1);
      last_owner = owners[k];
    end
    owners[4] = pick(1'b0, 1'b1);
    if (n == 5) last_owner = owners[4];
    last_cyc = 4 * n - 1;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h005;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h006;
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      logic [1:0] want;
      @(negedge clk);
      want = (cyc % 4 == 3) ? code(owners[(cyc - 3) / 4]) : 2'b00;
      vectors++;
      if ({b_ready, a_ready} !== want) begin
        miscompares++;
        $display("FAIL contention_ready_cycle%0d got %b want %b", cyc,
                 {b_ready, a_ready}, want);
      end
      if (want == 2'b01) exp_a_rdata = ref_mem[10'h005];
      if (want == 2'b10) exp_b_rdata = ref_mem[10'h006];
      if (want != 2'b00) begin
        vectors++;
        if (a_rdata !== exp_a_rdata || b_rdata !== exp_b_rdata) begin
          miscompares++;
          $display("FAIL contention_rdata got a=%h b=%h want a=%h b=%h", a_rdata,
                   b_rdata, exp_a_rdata, exp_b_rdata);
        end
      end
      if (cyc == 15) begin
        a_req = 1'b0;
        if (RR) b_req = 1'b0;
      end
      if (cyc == last_cyc) b_req = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int mode;
      logic [ADDR_W-1:0] aa, ab;
      mode = $urandom_range(0, 2);
      aa = ADDR_W'($urandom_range(0, 15));
      ab = ADDR_W'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) aa = ADDR_W'($urandom);
      run_txn(mode != 1, mode != 0, 1'($urandom), 1'($urandom), aa, ab,
              $urandom, $urandom, 3);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h155; a_wdata = 32'hCAFEF00D;
    @(negedge clk);
    vectors++;
    if (ram_we !== 1'b1 || grant !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_access got we=%b grant=%b want 1/01", ram_we, grant);
    end
    #1 RSTN = 1'b0;
    #1;
    vectors++;
    if (ram_we !== 1'b0 || grant !== 2'b00 || ram_addr !== '0 || ram_din !== '0) begin
      miscompares++;
      $display("FAIL async_reset got we=%b grant=%b addr=%h din=%h want 0/00/0/0",
               ram_we, grant, ram_addr, ram_din);
    end
    vectors++;
    if (a_rdata !== '0 || b_rdata !== '0) begin
      miscompares++;
      $display("FAIL async_reset_rdata got a=%h b=%h want 0/0", a_rdata, b_rdata);
    end
    a_req = 1'b0;
    model_reset();
    @(negedge clk);
    RSTN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({b_ready, a_ready} !== 2'b00 || grant !== 2'b00) begin
        miscompares++;
        $display("FAIL post_reset_idle got ready=%b grant=%b want 00/00",
                 {b_ready, a_ready}, grant);
      end
    end
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 10'h155, '0, '0, '0, 3);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = 32'(i) * 32'h9E3779B1;
    test_reset();
    test_write_read();
    test_drop_req();
    test_contention();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
